// File: rtl/game_ctrl.sv
// Game-flow sequencer for the VGA overlay chain: debounced jump button,
// IDLE/PLAY/END state machine, per-layer enables, time-bar restart and score.
module game_ctrl #(
  parameter int unsigned          N_LAYERS    = 7,
  parameter logic [N_LAYERS-1:0]  IDLE_MASK   = 7'b0000011,
  parameter logic [N_LAYERS-1:0]  PLAY_MASK   = 7'b0111101,
  parameter logic [N_LAYERS-1:0]  END_MASK    = 7'b1100001,
  parameter int unsigned          DEBOUNCE_MS = 20,
  parameter int unsigned          END_HOLD_MS = 1000,
  parameter int unsigned          SCORE_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                one_ms_tick,
  input  logic                btn_raw,
  input  logic                landed,
  input  logic                fell,
  input  logic                time_elapsed,
  input  logic                override_mode,
  input  logic [N_LAYERS-1:0] sw_override,
  output logic [N_LAYERS-1:0] layer_en,
  output logic                time_bar_start,
  output logic                points_inc,
  output logic                jump,
  output logic [SCORE_W-1:0]  score,
  output logic [1:0]          state
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HOLD_W = $clog2(END_HOLD_MS + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(END_HOLD_MS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_END  = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  logic              r_btn_s1;
  logic              r_btn_s2;
  logic              r_btn_db;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_press;

  state_t              r_state;
  state_t              w_next_state;
  logic [N_LAYERS-1:0] w_next_mask;
  logic [N_LAYERS-1:0] r_layer_en;
  logic [SCORE_W-1:0]  r_score;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_time_bar_start;
  logic                r_points_inc;
  logic                r_jump;

  // Synchroniser and tick-sampled debouncer; press fires on the accepted rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_press  <= 1'b0;
      if (one_ms_tick) begin
        if (r_btn_s2 == r_btn_db) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_btn_s2;
          r_db_cnt <= '0;
          r_press  <= r_btn_s2;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (r_press) w_next_state = S_PLAY;
      S_PLAY: if (fell || time_elapsed) w_next_state = S_END;
      S_END:  if (r_press && (r_hold == HOLD_MAX)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_mask = IDLE_MASK;
    case (w_next_state)
      S_PLAY:  w_next_mask = PLAY_MASK;
      S_END:   w_next_mask = END_MASK;
      default: w_next_mask = IDLE_MASK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_layer_en       <= IDLE_MASK;
      r_score          <= '0;
      r_hold           <= '0;
      r_time_bar_start <= 1'b0;
      r_points_inc     <= 1'b0;
      r_jump           <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_layer_en       <= override_mode ? sw_override : w_next_mask;
      r_time_bar_start <= 1'b0;
      r_points_inc     <= 1'b0;
      r_jump           <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_press) begin
            r_score          <= '0;
            r_time_bar_start <= 1'b1;
          end
        end
        S_PLAY: begin
          // Game over wins over anything else seen in the same cycle.
          if (fell || time_elapsed) begin
            r_hold <= '0;
          end else begin
            if (r_press) r_jump <= 1'b1;
            if (landed) begin
              if (r_score != '1) r_score <= r_score + SCORE_W'(1);
              r_points_inc     <= 1'b1;
              r_time_bar_start <= 1'b1;
            end
          end
        end
        S_END: begin
          if (one_ms_tick && (r_hold != HOLD_MAX)) r_hold <= r_hold + HOLD_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign layer_en       = r_layer_en;
  assign time_bar_start = r_time_bar_start;
  assign points_inc     = r_points_inc;
  assign jump           = r_jump;
  assign score          = r_score;
  assign state          = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: vector table for the PLAY/END scoring path plus
// hand-written debounce, END-hold, override and asynchronous-reset sequences.
module tb_game_ctrl;

  localparam int TICK_CYC = 8;

  logic       clk;
  logic       rst;
  logic       one_ms_tick;
  logic       btn_raw;
  logic       landed;
  logic       fell;
  logic       time_elapsed;
  logic       override_mode;
  logic [6:0] sw_override;

  logic [6:0] layer_en;
  logic       time_bar_start;
  logic       points_inc;
  logic       jump;
  logic [7:0] score;
  logic [1:0] state;

  logic [6:0] layer_en2;
  logic       time_bar_start2;
  logic       points_inc2;
  logic       jump2;
  logic [1:0] score2;
  logic [1:0] state2;

  int n_checks = 0;
  int n_err    = 0;
  int ms       = 0;
  int n_tbs = 0, n_pinc = 0, n_jump = 0, tbs_ms = 0;
  int n_tbs2 = 0, n_pinc2 = 0, n_jump2 = 0;

  game_ctrl dut (
    .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick), .btn_raw(btn_raw),
    .landed(landed), .fell(fell), .time_elapsed(time_elapsed),
    .override_mode(override_mode), .sw_override(sw_override),
    .layer_en(layer_en), .time_bar_start(time_bar_start), .points_inc(points_inc),
    .jump(jump), .score(score), .state(state)
  );

  game_ctrl #(.SCORE_W(2)) dut2 (
    .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick), .btn_raw(btn_raw),
    .landed(landed), .fell(fell), .time_elapsed(time_elapsed),
    .override_mode(override_mode), .sw_override(sw_override),
    .layer_en(layer_en2), .time_bar_start(time_bar_start2), .points_inc(points_inc2),
    .jump(jump2), .score(score2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    one_ms_tick = 1'b0;
    forever begin
      repeat (TICK_CYC - 1) @(posedge clk);
      #1 one_ms_tick = 1'b1;
      ms = ms + 1;
      @(posedge clk);
      #1 one_ms_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (time_bar_start) begin n_tbs = n_tbs + 1; tbs_ms = ms; end
      if (points_inc) n_pinc = n_pinc + 1;
      if (jump) n_jump = n_jump + 1;
      if (time_bar_start2) n_tbs2 = n_tbs2 + 1;
      if (points_inc2) n_pinc2 = n_pinc2 + 1;
      if (jump2) n_jump2 = n_jump2 + 1;
    end
  end

  typedef struct {
    logic       landed, fell, te, ovr;
    logic [1:0] st;
    logic [7:0] sc;
    logic [1:0] sc2;
    logic       pinc, tbs;
    logic [6:0] layer;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic l, logic f, logic t, logic o, logic [1:0] st,
                              logic [7:0] sc, logic [1:0] sc2, logic pinc, logic tbs,
                              logic [6:0] layer);
    vec_t v;
    v.landed = l; v.fell = f; v.te = t; v.ovr = o; v.st = st; v.sc = sc;
    v.sc2 = sc2; v.pinc = pinc; v.tbs = tbs; v.layer = layer;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ms(input int n);
    if (n > 0) repeat (n * TICK_CYC) @(posedge clk);
    #1;
  endtask

  task automatic press_hold(input int on_ms, input int off_ms);
    btn_raw = 1'b1;
    wait_ms(on_ms);
    btn_raw = 1'b0;
    wait_ms(off_ms);
  endtask

  localparam logic [6:0] M_IDLE = 7'b0000011;
  localparam logic [6:0] M_PLAY = 7'b0111101;
  localparam logic [6:0] M_END  = 7'b1100001;
  localparam logic [6:0] M_SW   = 7'b1010101;

  initial begin
    int start_ms, d, end_ms, got;
    rst = 1'b0; btn_raw = 1'b0; landed = 1'b0; fell = 1'b0; time_elapsed = 1'b0;
    override_mode = 1'b0; sw_override = M_SW;

    vecs[0]  = mk(1, 0, 0, 0, 2'd1, 8'd1, 2'd1, 1, 1, M_PLAY);
    vecs[1]  = mk(0, 0, 0, 0, 2'd1, 8'd1, 2'd1, 0, 0, M_PLAY);
    vecs[2]  = mk(1, 0, 0, 0, 2'd1, 8'd2, 2'd2, 1, 1, M_PLAY);
    vecs[3]  = mk(1, 0, 0, 0, 2'd1, 8'd3, 2'd3, 1, 1, M_PLAY);
    vecs[4]  = mk(0, 0, 0, 0, 2'd1, 8'd3, 2'd3, 0, 0, M_PLAY);
    vecs[5]  = mk(1, 0, 0, 0, 2'd1, 8'd4, 2'd3, 1, 1, M_PLAY);
    vecs[6]  = mk(1, 0, 0, 0, 2'd1, 8'd5, 2'd3, 1, 1, M_PLAY);
    vecs[7]  = mk(0, 0, 0, 1, 2'd1, 8'd5, 2'd3, 0, 0, M_SW);
    vecs[8]  = mk(1, 0, 0, 1, 2'd1, 8'd6, 2'd3, 1, 1, M_SW);
    vecs[9]  = mk(0, 0, 0, 0, 2'd1, 8'd6, 2'd3, 0, 0, M_PLAY);
    vecs[10] = mk(1, 0, 1, 0, 2'd2, 8'd6, 2'd3, 0, 0, M_END);
    vecs[11] = mk(1, 0, 0, 0, 2'd2, 8'd6, 2'd3, 0, 0, M_END);
    vecs[12] = mk(0, 1, 0, 0, 2'd2, 8'd6, 2'd3, 0, 0, M_END);
    vecs[13] = mk(0, 0, 0, 0, 2'd2, 8'd6, 2'd3, 0, 0, M_END);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_layer", layer_en, M_IDLE);
    chk("rst_layer2", layer_en2, M_IDLE);
    chk("rst_score", score, 8'd0);
    chk("rst_pulses", {time_bar_start, points_inc, jump}, 3'b000);
    rst = 1'b1;
    wait_ms(3);

    // Clean press starts the game about 20 ms later.
    start_ms = ms;
    press_hold(25, 25);
    d = tbs_ms - start_ms;
    chk("start_tbs_count", n_tbs, 1);
    chk("start_latency_19_21", (d >= 19 && d <= 21), 1);
    chk("start_state", state, 2'd1);
    chk("start_layer", layer_en, M_PLAY);
    chk("start_score", score, 8'd0);
    chk("start_no_jump", n_jump, 0);

    for (int k = 0; k < 5; k++) begin
      btn_raw = 1'b1; wait_ms(3);
      btn_raw = 1'b0; wait_ms(3);
    end
    wait_ms(25);
    chk("bounce_no_jump", n_jump, 0);
    chk("bounce_state", state, 2'd1);

    press_hold(25, 25);
    chk("jump_count", n_jump, 1);
    chk("jump_state", state, 2'd1);
    chk("jump_no_tbs", n_tbs, 1);

    for (int i = 0; i < 14; i++) begin
      landed = vecs[i].landed; fell = vecs[i].fell; time_elapsed = vecs[i].te;
      override_mode = vecs[i].ovr;
      @(posedge clk);
      #1;
      landed = 1'b0; fell = 1'b0; time_elapsed = 1'b0;
      chk($sformatf("v%0d_state", i), state, vecs[i].st);
      chk($sformatf("v%0d_state2", i), state2, vecs[i].st);
      chk($sformatf("v%0d_score", i), score, vecs[i].sc);
      chk($sformatf("v%0d_score2", i), score2, vecs[i].sc2);
      chk($sformatf("v%0d_pinc", i), points_inc, vecs[i].pinc);
      chk($sformatf("v%0d_pinc2", i), points_inc2, vecs[i].pinc);
      chk($sformatf("v%0d_tbs", i), time_bar_start, vecs[i].tbs);
      chk($sformatf("v%0d_layer", i), layer_en, vecs[i].layer);
      if (i == 10) end_ms = ms;
    end
    override_mode = 1'b0;
    chk("sat_pinc2_total", n_pinc2, 6);

    // Press accepted near 500 ms into END must be ignored.
    wait_ms(478 - (ms - end_ms));
    press_hold(25, 25);
    chk("hold_ignore_state", state, 2'd2);
    chk("hold_ignore_layer", layer_en, M_END);

    wait_ms(1180 - (ms - end_ms));
    chk("pre_exit_state", state, 2'd2);
    btn_raw = 1'b1;
    got = 0;
    for (int c = 0; c < 40 * TICK_CYC; c++) begin
      @(posedge clk);
      #1;
      if (state == 2'd0) begin got = 1; break; end
    end
    chk("end_exit_seen", got, 1);
    chk("end_exit_layer", layer_en, M_IDLE);
    chk("end_exit_score_held", score, 8'd6);
    btn_raw = 1'b0;
    wait_ms(25);

    press_hold(25, 25);
    chk("replay_state", state, 2'd1);
    chk("replay_score", score, 8'd0);
    chk("replay_score2", score2, 2'd0);

    override_mode = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_layer", layer_en, M_SW);
    landed = 1'b1;
    @(posedge clk);
    #1;
    landed = 1'b0;
    chk("ovr_score", score, 8'd1);
    chk("ovr_state", state, 2'd1);
    chk("ovr_layer_hold", layer_en, M_SW);

    // Reset asserted between clock edges must act without waiting for clk.
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_score", score, 8'd0);
    chk("async_rst_score2", score2, 2'd0);
    chk("async_rst_layer", layer_en, M_IDLE);
    override_mode = 1'b0;

    chk("dut2_tbs_match", n_tbs2, n_tbs);
    chk("dut2_jump_match", n_jump2, n_jump);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
